// File: rtl/msx_cart_responder.sv
// msx_cart_responder: cartridge end of the MSX slot bus. Decodes slot memory and
// I/O cycles, maps pages 1-2 through four 8 KB banks, fetches reads from a byte store.
module msx_cart_responder #(
  parameter logic [7:0]  PORT_BASE = 8'h30,
  parameter int unsigned WAIT_MAX  = 64,
  parameter logic [7:0]  TO_DATA   = 8'hFF
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [15:0] addr_i,
  inout  wire  [7:0]  data_io,
  input  logic        rd_n_i,
  input  logic        wr_n_i,
  input  logic        mreq_n_i,
  input  logic        iorq_n_i,
  input  logic        m1_n_i,
  input  logic        sltsl_n_i,
  output logic        wait_n_o,
  output logic        busdir_n_o,
  output logic [20:0] mem_addr_o,
  output logic        mem_rd_o,
  input  logic        mem_ack_i,
  input  logic [7:0]  mem_data_i,
  output logic [7:0]  io_wdata_o,
  output logic        io_wstb_o,
  input  logic [7:0]  io_rdata_i
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_MRD     = 3'd1,
    S_DRIVE   = 3'd2,
    S_IODRIVE = 3'd3,
    S_HOLD    = 3'd4
  } state_t;

  localparam int unsigned CW = $clog2(WAIT_MAX + 1);

  logic [5:0]    strb_meta_q;
  logic [5:0]    strb_sync_q;
  logic          rd_prev_q;
  logic          wr_prev_q;
  logic          rd_n_s, wr_n_s, mreq_n_s, iorq_n_s, m1_n_s, sltsl_n_s;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          wait_n_q, wait_n_d;
  logic          busdir_n_q, busdir_n_d;
  logic          data_oe_q, data_oe_d;
  logic [7:0]    dout_q, dout_d;
  logic          mem_rd_q, mem_rd_d;
  logic [20:0]   mem_addr_q, mem_addr_d;
  logic [7:0]    io_wdata_q, io_wdata_d;
  logic          io_wstb_q, io_wstb_d;
  logic [7:0]    bank_q [4];
  logic [7:0]    bank_d [4];

  logic          start_s, is_read_s, is_write_s, inta_s;
  logic          mem_sel_s, io_sel_s, page12_s, mapper_s;
  logic [1:0]    rd_bank_s;
  logic [7:0]    data_in_s;

  assign {rd_n_s, wr_n_s, mreq_n_s, iorq_n_s, m1_n_s, sltsl_n_s} = strb_sync_q;

  // Two-flop synchronizers on the strobes plus previous-cycle copies for edge detect
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      strb_meta_q <= 6'h3F;
      strb_sync_q <= 6'h3F;
      rd_prev_q   <= 1'b1;
      wr_prev_q   <= 1'b1;
    end else begin
      strb_meta_q <= {rd_n_i, wr_n_i, mreq_n_i, iorq_n_i, m1_n_i, sltsl_n_i};
      strb_sync_q <= strb_meta_q;
      rd_prev_q   <= rd_n_s;
      wr_prev_q   <= wr_n_s;
    end
  end

  assign start_s    = (~rd_n_s & rd_prev_q) | (~wr_n_s & wr_prev_q);
  assign is_read_s  = ~rd_n_s & wr_n_s;
  assign is_write_s = ~wr_n_s & rd_n_s;
  assign inta_s     = ~iorq_n_s & ~m1_n_s;
  assign mem_sel_s  = ~mreq_n_s & ~sltsl_n_s & ~inta_s;
  assign io_sel_s   = ~iorq_n_s & m1_n_s & (addr_i[7:0] == PORT_BASE);
  assign page12_s   = addr_i[15] ^ addr_i[14];
  assign mapper_s   = (addr_i[15:13] == 3'b011);
  // 0x4000 -> bank0 ... 0xA000 -> bank3
  assign rd_bank_s  = {~addr_i[14], addr_i[13]};
  assign data_in_s  = data_io;

  // Cycle sequencing, bank writes and output next-state
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wait_n_d   = wait_n_q;
    busdir_n_d = busdir_n_q;
    data_oe_d  = data_oe_q;
    dout_d     = dout_q;
    mem_rd_d   = mem_rd_q;
    mem_addr_d = mem_addr_q;
    io_wdata_d = io_wdata_q;
    io_wstb_d  = 1'b0;
    bank_d     = bank_q;
    case (state_q)
      S_IDLE: begin
        if (start_s && mem_sel_s && is_read_s && page12_s) begin
          mem_addr_d = {bank_q[rd_bank_s], addr_i[12:0]};
          mem_rd_d   = 1'b1;
          wait_n_d   = 1'b0;
          cnt_d      = '0;
          state_d    = S_MRD;
        end else if (start_s && mem_sel_s && is_write_s && mapper_s) begin
          bank_d[addr_i[12:11]] = data_in_s;
          state_d               = S_HOLD;
        end else if (start_s && io_sel_s && is_read_s) begin
          dout_d     = io_rdata_i;
          data_oe_d  = 1'b1;
          busdir_n_d = 1'b0;
          state_d    = S_IODRIVE;
        end else if (start_s && io_sel_s && is_write_s) begin
          io_wdata_d = data_in_s;
          io_wstb_d  = 1'b1;
          state_d    = S_HOLD;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_MRD: begin
        if (mem_ack_i) begin
          dout_d    = mem_data_i;
          data_oe_d = 1'b1;
          mem_rd_d  = 1'b0;
          wait_n_d  = 1'b1;
          state_d   = S_DRIVE;
        end else if (cnt_q == CW'(WAIT_MAX - 1)) begin
          dout_d    = TO_DATA;
          data_oe_d = 1'b1;
          mem_rd_d  = 1'b0;
          wait_n_d  = 1'b1;
          state_d   = S_DRIVE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DRIVE: begin
        if (rd_n_s) begin
          data_oe_d = 1'b0;
          cnt_d     = '0;
          state_d   = S_IDLE;
        end else begin
          state_d = S_DRIVE;
        end
      end
      S_IODRIVE: begin
        if (rd_n_s) begin
          data_oe_d  = 1'b0;
          busdir_n_d = 1'b1;
          state_d    = S_IDLE;
        end else begin
          state_d = S_IODRIVE;
        end
      end
      S_HOLD: begin
        if (wr_n_s) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_HOLD;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      wait_n_q   <= 1'b1;
      busdir_n_q <= 1'b1;
      data_oe_q  <= 1'b0;
      dout_q     <= 8'h00;
      mem_rd_q   <= 1'b0;
      mem_addr_q <= 21'h000000;
      io_wdata_q <= 8'h00;
      io_wstb_q  <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        bank_q[i] <= 8'h00;
      end
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wait_n_q   <= wait_n_d;
      busdir_n_q <= busdir_n_d;
      data_oe_q  <= data_oe_d;
      dout_q     <= dout_d;
      mem_rd_q   <= mem_rd_d;
      mem_addr_q <= mem_addr_d;
      io_wdata_q <= io_wdata_d;
      io_wstb_q  <= io_wstb_d;
      for (int i = 0; i < 4; i++) begin
        bank_q[i] <= bank_d[i];
      end
    end
  end

  assign data_io    = data_oe_q ? dout_q : 8'hzz;
  assign wait_n_o   = wait_n_q;
  assign busdir_n_o = busdir_n_q;
  assign mem_addr_o = mem_addr_q;
  assign mem_rd_o   = mem_rd_q;
  assign io_wdata_o = io_wdata_q;
  assign io_wstb_o  = io_wstb_q;

endmodule

// File: tb/tb_msx_cart_responder.sv
// tb_msx_cart_responder: table of MSX bus cycles with expected results queued per
// cycle, plus hand-written reset and reset-during-read sequences.
module tb_msx_cart_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [15:0] addr;
  logic        rd_n, wr_n, mreq_n, iorq_n, m1_n, sltsl_n;
  logic        tb_oe;
  logic [7:0]  tb_dout;
  wire  [7:0]  data_bus;
  logic        wait_n, busdir_n, mem_rd, mem_ack, io_wstb;
  logic [20:0] mem_addr;
  logic [7:0]  mem_data, io_wdata, io_rdata;

  int checks = 0;
  int failures = 0;

  assign data_bus = tb_oe ? tb_dout : 8'hzz;
  for (genvar g = 0; g < 8; g++) begin : g_pd
    pulldown pd (data_bus[g]);
  end

  msx_cart_responder dut (
    .clk_i(clk), .reset_i(reset), .addr_i(addr), .data_io(data_bus),
    .rd_n_i(rd_n), .wr_n_i(wr_n), .mreq_n_i(mreq_n), .iorq_n_i(iorq_n),
    .m1_n_i(m1_n), .sltsl_n_i(sltsl_n), .wait_n_o(wait_n), .busdir_n_o(busdir_n),
    .mem_addr_o(mem_addr), .mem_rd_o(mem_rd), .mem_ack_i(mem_ack),
    .mem_data_i(mem_data), .io_wdata_o(io_wdata), .io_wstb_o(io_wstb),
    .io_rdata_i(io_rdata)
  );

  typedef struct {
    string       name;
    bit          io;
    bit          wr;
    logic [15:0] a;
    logic [7:0]  wd;
    bit          slt_n;
    bit          m1n;
    int          ack_dly;   // MEM_RD cycles before ack; 0 = never
    logic [7:0]  md;
    bit          late;      // stray ack after WAIT release
    logic [7:0]  ior;
    bit          e_mrd;
    logic [20:0] e_maddr;
    int          e_wait;
    bit          e_rd_chk;
    logic [7:0]  e_data;
    bit          e_busdir;
    int          e_wstb;
    logic [7:0]  e_iowd;
  } vec_t;

  vec_t vt[$];
  vec_t exp_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    vec_t        e;
    int          k, rd_cnt, wait_low, wait_first, wstb_cnt, hold;
    bit          mrd_seen, done;
    logic [20:0] maddr_obs;
    logic [7:0]  data_end;
    logic        bd_end;
    k = 0; rd_cnt = 0; wait_low = 0; wait_first = -1; wstb_cnt = 0; hold = 0;
    mrd_seen = 1'b0; done = 1'b0; maddr_obs = 21'h0; data_end = 8'h00; bd_end = 1'b1;
    exp_q.push_back(v);
    @(negedge clk);
    addr = v.a; sltsl_n = v.slt_n; m1_n = v.m1n; io_rdata = v.ior;
    if (v.io) iorq_n = 1'b0; else mreq_n = 1'b0;
    if (v.wr) begin tb_oe = 1'b1; tb_dout = v.wd; end
    @(negedge clk);
    if (v.wr) wr_n = 1'b0; else rd_n = 1'b0;
    while (!done && k < 150) begin
      @(negedge clk);
      k++;
      mem_ack = 1'b0;
      if (mem_rd) begin
        if (!mrd_seen) maddr_obs = mem_addr;
        mrd_seen = 1'b1;
        rd_cnt++;
        if (rd_cnt == v.ack_dly) begin mem_ack = 1'b1; mem_data = v.md; end
      end
      if (!wait_n) begin
        if (wait_first < 0) wait_first = k;
        wait_low++;
      end
      if (io_wstb) wstb_cnt++;
      if (k >= 5 && wait_n) begin
        if (hold == 0 && v.late && wait_low > 0) begin mem_ack = 1'b1; mem_data = 8'h77; end
        if (hold == 3) begin
          data_end = data_bus; bd_end = busdir_n; done = 1'b1;
        end
        hold++;
      end
    end
    mem_ack = 1'b0;
    if (!done) begin
      checks++; failures++;
      $display("FAIL %s.cycle_bound actual=no_release required=release_within_150", v.name);
    end
    rd_n = 1'b1; wr_n = 1'b1; mreq_n = 1'b1; iorq_n = 1'b1; m1_n = 1'b1; sltsl_n = 1'b1;
    tb_oe = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (io_wstb) wstb_cnt++;
    end
    e = exp_q.pop_front();
    chk({e.name, ".mem_rd"}, 32'(mrd_seen), 32'(e.e_mrd));
    if (e.e_mrd) begin
      chk({e.name, ".mem_addr"}, 32'(maddr_obs), 32'(e.e_maddr));
      chk({e.name, ".wait_start"}, 32'(wait_first), 32'd3);
    end
    chk({e.name, ".wait_cycles"}, 32'(wait_low), 32'(e.e_wait));
    if (e.e_rd_chk) chk({e.name, ".data"}, 32'(data_end), 32'(e.e_data));
    chk({e.name, ".busdir_n"}, 32'(bd_end), 32'(e.e_busdir));
    chk({e.name, ".io_wstb"}, 32'(wstb_cnt), 32'(e.e_wstb));
    chk({e.name, ".io_wdata"}, 32'(io_wdata), 32'(e.e_iowd));
    chk({e.name, ".post_data_z"}, 32'(data_bus), 32'h00);
    chk({e.name, ".post_busdir"}, 32'(busdir_n), 32'h1);
    chk({e.name, ".post_wait"}, 32'(wait_n), 32'h1);
  endtask

  initial begin
    int k;
    reset = 1'b1; addr = 16'h0000; rd_n = 1'b1; wr_n = 1'b1; mreq_n = 1'b1;
    iorq_n = 1'b1; m1_n = 1'b1; sltsl_n = 1'b1; tb_oe = 1'b0; tb_dout = 8'h00;
    mem_ack = 1'b0; mem_data = 8'h00; io_rdata = 8'h00;

    //          name       io    wr    addr      wd     slt   m1n   ack mdata  late  ior     mrd   maddr       wait rdchk data   bdir  wstb iowd
    vt.push_back('{"rd4005", 1'b0, 1'b0, 16'h4005, 8'h00, 1'b0, 1'b1, 5, 8'hA5, 1'b0, 8'h00, 1'b1, 21'h000005, 5,  1'b1, 8'hA5, 1'b1, 0, 8'h00});
    vt.push_back('{"wr6800", 1'b0, 1'b1, 16'h6800, 8'h12, 1'b0, 1'b1, 0, 8'h00, 1'b0, 8'h00, 1'b0, 21'h000000, 0,  1'b0, 8'h00, 1'b1, 0, 8'h00});
    vt.push_back('{"rd6123", 1'b0, 1'b0, 16'h6123, 8'h00, 1'b0, 1'b1, 2, 8'h3C, 1'b0, 8'h00, 1'b1, 21'h024123, 2,  1'b1, 8'h3C, 1'b1, 0, 8'h00});
    vt.push_back('{"iow30",  1'b1, 1'b1, 16'h0030, 8'h5C, 1'b1, 1'b1, 0, 8'h00, 1'b0, 8'h00, 1'b0, 21'h000000, 0,  1'b0, 8'h00, 1'b1, 1, 8'h5C});
    vt.push_back('{"ior30",  1'b1, 1'b0, 16'h0030, 8'h00, 1'b1, 1'b1, 0, 8'h00, 1'b0, 8'h3E, 1'b0, 21'h000000, 0,  1'b1, 8'h3E, 1'b0, 0, 8'h5C});
    vt.push_back('{"rd_tmo", 1'b0, 1'b0, 16'h8010, 8'h00, 1'b0, 1'b1, 0, 8'h00, 1'b1, 8'h00, 1'b1, 21'h000010, 64, 1'b1, 8'hFF, 1'b1, 0, 8'h5C});
    vt.push_back('{"rd_slt1",1'b0, 1'b0, 16'h4005, 8'h00, 1'b1, 1'b1, 1, 8'h99, 1'b0, 8'h3E, 1'b0, 21'h000000, 0,  1'b1, 8'h00, 1'b1, 0, 8'h5C});
    vt.push_back('{"inta",   1'b1, 1'b0, 16'h0030, 8'h00, 1'b1, 1'b0, 0, 8'h00, 1'b0, 8'h3E, 1'b0, 21'h000000, 0,  1'b1, 8'h00, 1'b1, 0, 8'h5C});
    vt.push_back('{"ior31",  1'b1, 1'b0, 16'h0031, 8'h00, 1'b1, 1'b1, 0, 8'h00, 1'b0, 8'h3E, 1'b0, 21'h000000, 0,  1'b1, 8'h00, 1'b1, 0, 8'h5C});
    vt.push_back('{"iow31",  1'b1, 1'b1, 16'h0031, 8'h99, 1'b1, 1'b1, 0, 8'h00, 1'b0, 8'h00, 1'b0, 21'h000000, 0,  1'b0, 8'h00, 1'b1, 0, 8'h5C});
    vt.push_back('{"wrA000", 1'b0, 1'b1, 16'hA000, 8'h7F, 1'b0, 1'b1, 0, 8'h00, 1'b0, 8'h00, 1'b0, 21'h000000, 0,  1'b0, 8'h00, 1'b1, 0, 8'h5C});
    vt.push_back('{"wr7800", 1'b0, 1'b1, 16'h7800, 8'h81, 1'b0, 1'b1, 0, 8'h00, 1'b0, 8'h00, 1'b0, 21'h000000, 0,  1'b0, 8'h00, 1'b1, 0, 8'h5C});
    vt.push_back('{"rdA001", 1'b0, 1'b0, 16'hA001, 8'h00, 1'b0, 1'b1, 1, 8'h11, 1'b0, 8'h00, 1'b1, 21'h102001, 1,  1'b1, 8'h11, 1'b1, 0, 8'h5C});
    vt.push_back('{"rd4000", 1'b0, 1'b0, 16'h4000, 8'h00, 1'b0, 1'b1, 3, 8'h5A, 1'b0, 8'h00, 1'b1, 21'h000000, 3,  1'b1, 8'h5A, 1'b1, 0, 8'h5C});
    vt.push_back('{"rd0100", 1'b0, 1'b0, 16'h0100, 8'h00, 1'b0, 1'b1, 1, 8'h66, 1'b0, 8'h00, 1'b0, 21'h000000, 0,  1'b1, 8'h00, 1'b1, 0, 8'h5C});
    vt.push_back('{"wr6000", 1'b0, 1'b1, 16'h6000, 8'h03, 1'b0, 1'b1, 0, 8'h00, 1'b0, 8'h00, 1'b0, 21'h000000, 0,  1'b0, 8'h00, 1'b1, 0, 8'h5C});
    vt.push_back('{"rd5FFF", 1'b0, 1'b0, 16'h5FFF, 8'h00, 1'b0, 1'b1, 1, 8'h22, 1'b0, 8'h00, 1'b1, 21'h007FFF, 1,  1'b1, 8'h22, 1'b1, 0, 8'h5C});

    repeat (4) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset.wait_n", 32'(wait_n), 32'h1);
    chk("reset.busdir_n", 32'(busdir_n), 32'h1);
    chk("reset.data_z", 32'(data_bus), 32'h00);
    chk("reset.mem_rd", 32'(mem_rd), 32'h0);
    chk("reset.mem_addr", 32'(mem_addr), 32'h0);
    chk("reset.io_wstb", 32'(io_wstb), 32'h0);
    chk("reset.io_wdata", 32'(io_wdata), 32'h0);

    foreach (vt[i]) run_vec(vt[i]);

    // Reset asserted while a memory read waits for its ack
    @(negedge clk);
    addr = 16'h4005; mreq_n = 1'b0; sltsl_n = 1'b0;
    @(negedge clk);
    rd_n = 1'b0;
    k = 0;
    while (!mem_rd && k < 20) begin @(negedge clk); k++; end
    chk("rst_mrd.reached", 32'(mem_rd), 32'h1);
    @(negedge clk);
    reset = 1'b1; rd_n = 1'b1; mreq_n = 1'b1; sltsl_n = 1'b1;
    @(negedge clk);
    chk("rst_mrd.wait_n", 32'(wait_n), 32'h1);
    chk("rst_mrd.busdir_n", 32'(busdir_n), 32'h1);
    chk("rst_mrd.mem_rd", 32'(mem_rd), 32'h0);
    chk("rst_mrd.mem_addr", 32'(mem_addr), 32'h0);
    chk("rst_mrd.data_z", 32'(data_bus), 32'h00);
    chk("rst_mrd.io_wdata", 32'(io_wdata), 32'h0);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    // bank1 held 0x12 before reset; it must read back as bank 0
    run_vec('{"rd7000", 1'b0, 1'b0, 16'h7000, 8'h00, 1'b0, 1'b1, 2, 8'h44, 1'b0, 8'h00, 1'b1, 21'h001000, 2, 1'b1, 8'h44, 1'b1, 0, 8'h00});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
